cdb_arbiter_rr: RTL and testbench

- Parametrised common-data-bus arbiter for the Tomasulo core: collects results from NUM_SRC functional units (load/store, ALU, mult, ...) into one shared ordered queue.
- Broadcasts one result per cycle (value, destination register, RS tag) to the register file and reservation stations.
- Successor of the fixed two-source arbiter. Adds N sources, configurable depth and widths, and fixed or round-robin priority.
- Adds a per-source valid/ack backpressure handshake, a flush for mispeculation, and occupancy status.

---
 rtl/cdb_arbiter_rr.sv | 121 ++++++++++++
 tb/tb_cdb_arbiter_rr.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_rr.sv
// rtl/cdb_arbiter_rr.sv - N-source common-data-bus arbiter feeding an ordered result queue
// One result per cycle is broadcast; an empty queue lets the first accepted result bypass.
module cdb_arbiter_rr #(
  parameter int NUM_SRC  = 4,
  parameter int DEPTH    = 8,
  parameter int DATA_W   = 16,
  parameter int DEST_W   = 3,
  parameter int TAG_W    = 4,
  parameter int ARB_MODE = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  input  logic [NUM_SRC*DEST_W-1:0]  src_dest,
  input  logic [NUM_SRC*TAG_W-1:0]   src_tag,
  output logic [NUM_SRC-1:0]         src_ack,
  output logic                       cdb_valid,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [DEST_W-1:0]          cdb_dest,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(NUM_SRC);
  localparam int NW = $clog2(NUM_SRC + 1);
  localparam int EW = DATA_W + DEST_W + TAG_W;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] start;
  logic [SW-1:0] last;
  logic [EW-1:0] entry [NUM_SRC];
  logic [SW-1:0] acc_idx [NUM_SRC];
  logic [NW-1:0] n_acc;
  logic [CW-1:0] avail;
  logic          deq;
  logic          bypass;
  logic          popped;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++)
      entry[i] = {src_data[i*DATA_W +: DATA_W], src_dest[i*DEST_W +: DEST_W], src_tag[i*TAG_W +: TAG_W]};
  end

  assign deq    = (count != '0);
  // A head leaving this edge frees its slot for this edge's writes.
  assign avail  = CW'(DEPTH) - count + CW'(deq);
  assign start  = (ARB_MODE != 0) ? rr_ptr : '0;
  assign bypass = !deq && (n_acc != '0);
  assign popped = deq || bypass;
  assign full   = (count == CW'(DEPTH));

  always_comb begin
    int na;
    int s;
    na      = 0;
    s       = 0;
    src_ack = '0;
    last    = '0;
    for (int j = 0; j < NUM_SRC; j++) acc_idx[j] = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      s = int'(start) + k;
      if (s >= NUM_SRC) s = s - NUM_SRC;
      if (!reset && !flush && src_valid[s] && na < int'(avail)) begin
        src_ack[s]  = 1'b1;
        acc_idx[na] = SW'(s);
        last        = SW'(s);
        na          = na + 1;
      end
    end
    n_acc = NW'(na);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
      cdb_dest  <= '0;
      cdb_tag   <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      cdb_valid <= 1'b0;
    end else begin
      if (deq) begin
        cdb_valid                      <= 1'b1;
        {cdb_data, cdb_dest, cdb_tag}  <= mem[head];
        head                           <= head + PW'(1);
      end else if (bypass) begin
        cdb_valid                      <= 1'b1;
        {cdb_data, cdb_dest, cdb_tag}  <= entry[acc_idx[0]];
      end else begin
        cdb_valid <= 1'b0;
      end
      tail  <= tail + PW'(n_acc - NW'(bypass));
      count <= count + CW'(n_acc) - CW'(popped);
      if (n_acc != '0)
        rr_ptr <= (int'(last) == NUM_SRC - 1) ? '0 : last + SW'(1);
    end
  end

  // The bypassed entry (slot 0 of the accepted list) is never stored.
  always_ff @(posedge clock) begin
    for (int j = 0; j < NUM_SRC; j++)
      if (j >= int'(bypass) && j < int'(n_acc))
        mem[tail + PW'(j - int'(bypass))] <= entry[acc_idx[j]];
  end

endmodule

// File: tb/tb_cdb_arbiter_rr.sv
// tb/tb_cdb_arbiter_rr.sv - table-driven bench with payload scoreboard for cdb_arbiter_rr
module tb_cdb_arbiter_rr;
  localparam int N  = 4;
  localparam int D  = 8;
  localparam int DW = 16;
  localparam int RW = 3;
  localparam int TW = 4;
  localparam int CW = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset;
  logic            flush;
  logic [N-1:0]    src_valid;
  logic [N*DW-1:0] src_data;
  logic [N*RW-1:0] src_dest;
  logic [N*TW-1:0] src_tag;
  logic [N-1:0]    src_ack;
  logic            cdb_valid;
  logic [DW-1:0]   cdb_data;
  logic [RW-1:0]   cdb_dest;
  logic [TW-1:0]   cdb_tag;
  logic [CW-1:0]   count;
  logic            full;

  logic            fx_flush;
  logic [N-1:0]    fx_valid;
  logic [N*DW-1:0] fx_data;
  logic [N*RW-1:0] fx_dest;
  logic [N*TW-1:0] fx_tag;
  logic [N-1:0]    fx_ack;
  logic            fx_cdb_valid;
  logic [DW-1:0]   fx_cdb_data;
  logic [RW-1:0]   fx_cdb_dest;
  logic [TW-1:0]   fx_cdb_tag;
  logic [CW-1:0]   fx_count;
  logic            fx_full;

  cdb_arbiter_rr #(.NUM_SRC(N), .DEPTH(D), .DATA_W(DW), .DEST_W(RW), .TAG_W(TW), .ARB_MODE(1)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .src_valid(src_valid), .src_data(src_data), .src_dest(src_dest), .src_tag(src_tag),
    .src_ack(src_ack), .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_dest(cdb_dest),
    .cdb_tag(cdb_tag), .count(count), .full(full)
  );

  cdb_arbiter_rr #(.NUM_SRC(N), .DEPTH(D), .DATA_W(DW), .DEST_W(RW), .TAG_W(TW), .ARB_MODE(0)) dut_fx (
    .clock(clock), .reset(reset), .flush(fx_flush),
    .src_valid(fx_valid), .src_data(fx_data), .src_dest(fx_dest), .src_tag(fx_tag),
    .src_ack(fx_ack), .cdb_valid(fx_cdb_valid), .cdb_data(fx_cdb_data), .cdb_dest(fx_cdb_dest),
    .cdb_tag(fx_cdb_tag), .count(fx_count), .full(fx_full)
  );

  typedef struct {
    logic         rst;
    logic         fl;
    logic [N-1:0] valid;
    int           first;
    logic [N-1:0] ack;
    int           cnt;
    logic         cv;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [RW-1:0] r;
    logic [TW-1:0] t;
  } ent_t;

  vec_t vq[$];
  ent_t sb[$];
  int   seq [N];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic fl, input logic [N-1:0] valid,
                              input int first, input logic [N-1:0] ack, input int cnt, input logic cv);
    vec_t v;
    v.rst = rst; v.fl = fl; v.valid = valid; v.first = first;
    v.ack = ack; v.cnt = cnt; v.cv = cv;
    return v;
  endfunction

  function automatic ent_t payload(input int s);
    ent_t e;
    e.d = 16'h00A5 + 16'(s * 256 + seq[s] * 16);
    e.r = 3'(3 + s + seq[s]);
    e.t = 4'(2 + s + seq[s]);
    return e;
  endfunction

  task automatic drive_payload();
    ent_t e;
    for (int s = 0; s < N; s++) begin
      e = payload(s);
      src_data[s*DW +: DW] = e.d;
      src_dest[s*RW +: RW] = e.r;
      src_tag[s*TW +: TW]  = e.t;
    end
  endtask

  initial begin
    ent_t e;
    int   ecnt;
    logic [N-1:0] eack;
    reset = 1'b1; flush = 1'b0; src_valid = '0;
    fx_flush = 1'b0; fx_valid = '0;
    fx_data = '0; fx_dest = '0; fx_tag = '0;
    for (int s = 0; s < N; s++) seq[s] = 0;
    drive_payload();

    //            rst   fl    valid    first ack      cnt cv
    vq.push_back(mk(1'b1, 1'b0, 4'b0000, 0, 4'b0000, 0, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 4'b1111, 0, 4'b0000, 0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 4'b0000, 0, 4'b0000, 0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 4'b0000, 0, 4'b0000, 0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 4'b0000, 0, 4'b0000, 0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 4'b0001, 0, 4'b0001, 0, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 4'b0000, 1, 4'b0000, 0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 4'b0010, 1, 4'b0010, 0, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 4'b1111, 2, 4'b1111, 3, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 4'b0000, 2, 4'b0000, 2, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 4'b0000, 2, 4'b0000, 1, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 4'b0000, 2, 4'b0000, 0, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 4'b0000, 2, 4'b0000, 0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 4'b1111, 2, 4'b1111, 3, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 4'b1111, 2, 4'b1111, 6, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 4'b0000, 2, 4'b0000, 5, 1'b1));
    vq.push_back(mk(1'b0, 1'b1, 4'b0011, 2, 4'b0000, 0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 4'b0001, 2, 4'b0001, 0, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 4'b1111, 1, 4'b1111, 3, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 4'b1111, 1, 4'b1111, 6, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 4'b1111, 1, 4'b1110, 8, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 4'b1111, 0, 4'b0001, 8, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 4'b1111, 1, 4'b0010, 8, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 4'b0000, 2, 4'b0000, 7, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 4'b0000, 2, 4'b0000, 6, 1'b1));
    vq.push_back(mk(1'b1, 1'b0, 4'b1111, 2, 4'b0000, 0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 4'b0000, 0, 4'b0000, 0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 4'b1000, 0, 4'b1000, 0, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 4'b0000, 0, 4'b0000, 0, 1'b0));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clock);
      reset = vq[i].rst; flush = vq[i].fl; src_valid = vq[i].valid;
      drive_payload();
      #1;
      chk($sformatf("ack[%0d]", i), 32'(src_ack), 32'(vq[i].ack));
      if (!vq[i].rst && !vq[i].fl) begin
        for (int k = 0; k < N; k++) begin
          int s;
          s = (vq[i].first + k) % N;
          if (vq[i].ack[s]) begin
            sb.push_back(payload(s));
            seq[s]++;
          end
        end
      end
      @(posedge clock);
      #1;
      if (vq[i].rst || vq[i].fl) sb.delete();
      chk($sformatf("count[%0d]", i), 32'(count), 32'(vq[i].cnt));
      chk($sformatf("full[%0d]", i), 32'(full), 32'(vq[i].cnt == D));
      chk($sformatf("cdb_valid[%0d]", i), 32'(cdb_valid), 32'(vq[i].cv));
      if (vq[i].rst) begin
        chk($sformatf("rst_data[%0d]", i), 32'(cdb_data), 32'd0);
        chk($sformatf("rst_dest[%0d]", i), 32'(cdb_dest), 32'd0);
        chk($sformatf("rst_tag[%0d]", i), 32'(cdb_tag), 32'd0);
      end else if (vq[i].cv) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty[%0d]: got broadcast expected queued entry", i);
        end else begin
          e = sb.pop_front();
          chk($sformatf("cdb_data[%0d]", i), 32'(cdb_data), 32'(e.d));
          chk($sformatf("cdb_dest[%0d]", i), 32'(cdb_dest), 32'(e.r));
          chk($sformatf("cdb_tag[%0d]", i), 32'(cdb_tag), 32'(e.t));
        end
      end
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Fixed priority: sources 0 and 3 fill the queue, then source 3 starves.
    reset = 1'b0; flush = 1'b0; src_valid = '0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clock);
      fx_valid = 4'b1001;
      eack = (k < 8) ? 4'b1001 : 4'b0001;
      ecnt = (k < 8) ? k + 1 : 8;
      #1;
      chk($sformatf("fx_ack[%0d]", k), 32'(fx_ack), 32'(eack));
      @(posedge clock);
      #1;
      chk($sformatf("fx_count[%0d]", k), 32'(fx_count), 32'(ecnt));
      chk($sformatf("fx_full[%0d]", k), 32'(fx_full), 32'(ecnt == D));
      chk($sformatf("fx_cdb_valid[%0d]", k), 32'(fx_cdb_valid), 32'd1);
    end
    @(negedge clock);
    fx_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
